counters_uart_monitor: RTL and testbench



---
 rtl/counters_uart_monitor.sv | 266 ++++++++++++++++++++++++++
 tb/tb_counters_uart_monitor.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/counters_uart_monitor.sv
// ---------------------------------------------------------------------------
// counters_uart_monitor
//
// FPGA top-level demo: a free-running 8-bit counter plus a small UART
// command monitor. A host on the serial link can send 'S' (0x53) to read
// the counter back as one byte, or 'C' (0x43) to clear it. Any other byte
// is ignored. RX and TX run independently (full duplex); an 'S' that
// arrives while a response is still being sent is dropped.
//
// Ports:
//   clk              in   1  system clock, everything on the rising edge
//   reset            in   1  synchronous, active-high reset
//   cntb             out  8  free-running counter value (registered)
//   uart_XMIT_dataH  out  1  UART TX line, 8N1, LSB first, idle high (registered)
//   uart_REC_dataH   in   1  UART RX line, 8N1, LSB first, idle high (async)
//
// Parameter:
//   CLKS_PER_BIT     clock cycles per UART bit, must be >= 4
// ---------------------------------------------------------------------------
module counters_uart_monitor #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] cntb,
    output logic       uart_XMIT_dataH,
    input  logic       uart_REC_dataH
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;

    // Terminal counts: a bit ends when the cycle counter reaches BIT_LAST;
    // the start bit is checked half a bit in, so later samples land mid-bit.
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [7:0] CMD_SNAP  = 8'h53;
    localparam logic [7:0] CMD_CLEAR = 8'h43;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rxState_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } txState_t;

    logic [7:0]    r_cntb;

    logic          r_rxSync1;
    logic          r_rxSync2;
    rxState_t      r_rxState;
    rxState_t      w_rxNext;
    logic [CW-1:0] r_rxClkCnt;
    logic [2:0]    r_rxBitIdx;
    logic [7:0]    r_rxShift;
    logic          r_rxValid;
    logic          w_rxTick;
    logic          w_rxIn;

    txState_t      r_txState;
    txState_t      w_txNext;
    logic [CW-1:0] r_txClkCnt;
    logic [2:0]    r_txBitIdx;
    logic [7:0]    r_txShift;
    logic          r_txLine;
    logic          w_txTick;
    logic          w_txBusy;
    logic          w_txLoad;

    logic          w_clearCmd;

    assign cntb            = r_cntb;
    assign uart_XMIT_dataH = r_txLine;
    assign w_rxIn          = r_rxSync2;

    // Command decode. r_rxShift still holds the received byte during the
    // single r_rxValid cycle because RX has just returned to IDLE.
    assign w_clearCmd = r_rxValid && (r_rxShift == CMD_CLEAR);
    assign w_txLoad   = r_rxValid && (r_rxShift == CMD_SNAP) && !w_txBusy;

    // Free-running counter. Reset beats clear, clear beats increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cntb <= 8'h00;
        end else if (w_clearCmd) begin
            r_cntb <= 8'h00;
        end else begin
            r_cntb <= r_cntb + 8'd1;
        end
    end

    // Two-flop synchronizer for the asynchronous RX pin. Resetting to the
    // idle level keeps RX from seeing a phantom start bit out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxSync1 <= 1'b1;
            r_rxSync2 <= 1'b1;
        end else begin
            r_rxSync1 <= uart_REC_dataH;
            r_rxSync2 <= r_rxSync1;
        end
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxState <= RX_IDLE;
        end else begin
            r_rxState <= w_rxNext;
        end
    end

    // RX next-state logic. A start bit that is high again at its midpoint
    // was a glitch, so RX drops straight back to IDLE.
    always_comb begin
        w_rxNext = r_rxState;
        case (r_rxState)
            RX_IDLE:  if (!w_rxIn) w_rxNext = RX_START;
            RX_START: if (w_rxTick) w_rxNext = w_rxIn ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rxTick && (r_rxBitIdx == 3'd7)) w_rxNext = RX_STOP;
            RX_STOP:  if (w_rxTick) w_rxNext = RX_IDLE;
        endcase
    end

    // RX output logic: the sampling strobe for the current state.
    always_comb begin
        w_rxTick = 1'b0;
        case (r_rxState)
            RX_IDLE:  w_rxTick = 1'b0;
            RX_START: w_rxTick = (r_rxClkCnt == HALF_LAST);
            RX_DATA:  w_rxTick = (r_rxClkCnt == BIT_LAST);
            RX_STOP:  w_rxTick = (r_rxClkCnt == BIT_LAST);
        endcase
    end

    // RX datapath: bit timing, LSB-first shift register, and the one-cycle
    // valid pulse that only fires when the stop bit is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxClkCnt <= '0;
            r_rxBitIdx <= 3'd0;
            r_rxShift  <= 8'h00;
            r_rxValid  <= 1'b0;
        end else begin
            r_rxValid <= 1'b0;
            case (r_rxState)
                RX_IDLE: begin
                    r_rxClkCnt <= '0;
                    r_rxBitIdx <= 3'd0;
                end
                RX_START: begin
                    r_rxClkCnt <= w_rxTick ? '0 : r_rxClkCnt + CW'(1);
                end
                RX_DATA: begin
                    if (w_rxTick) begin
                        r_rxClkCnt <= '0;
                        r_rxShift  <= {w_rxIn, r_rxShift[7:1]};
                        r_rxBitIdx <= r_rxBitIdx + 3'd1;
                    end else begin
                        r_rxClkCnt <= r_rxClkCnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (w_rxTick) begin
                        r_rxClkCnt <= '0;
                        r_rxValid  <= w_rxIn;
                    end else begin
                        r_rxClkCnt <= r_rxClkCnt + CW'(1);
                    end
                end
            endcase
        end
    end

    // TX state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_txState <= TX_IDLE;
        end else begin
            r_txState <= w_txNext;
        end
    end

    // TX next-state logic: one full bit period per state step.
    always_comb begin
        w_txNext = r_txState;
        case (r_txState)
            TX_IDLE:  if (w_txLoad) w_txNext = TX_START;
            TX_START: if (w_txTick) w_txNext = TX_DATA;
            TX_DATA:  if (w_txTick && (r_txBitIdx == 3'd7)) w_txNext = TX_STOP;
            TX_STOP:  if (w_txTick) w_txNext = TX_IDLE;
        endcase
    end

    // TX output logic: busy covers everything from load to end of stop bit.
    always_comb begin
        w_txBusy = 1'b1;
        w_txTick = (r_txClkCnt == BIT_LAST);
        if (r_txState == TX_IDLE) begin
            w_txBusy = 1'b0;
            w_txTick = 1'b0;
        end
    end

    // TX datapath. The line is registered and updated on the same edge that
    // moves to the next bit, so each level lasts exactly CLKS_PER_BIT cycles
    // and the start bit appears the cycle after the load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_txClkCnt <= '0;
            r_txBitIdx <= 3'd0;
            r_txShift  <= 8'h00;
            r_txLine   <= 1'b1;
        end else begin
            case (r_txState)
                TX_IDLE: begin
                    r_txClkCnt <= '0;
                    r_txBitIdx <= 3'd0;
                    r_txLine   <= 1'b1;
                    if (w_txLoad) begin
                        r_txShift <= r_cntb;
                        r_txLine  <= 1'b0;
                    end
                end
                TX_START: begin
                    if (w_txTick) begin
                        r_txClkCnt <= '0;
                        r_txLine   <= r_txShift[0];
                    end else begin
                        r_txClkCnt <= r_txClkCnt + CW'(1);
                    end
                end
                TX_DATA: begin
                    if (w_txTick) begin
                        r_txClkCnt <= '0;
                        r_txBitIdx <= r_txBitIdx + 3'd1;
                        if (r_txBitIdx == 3'd7) begin
                            r_txLine <= 1'b1;
                        end else begin
                            r_txShift <= {1'b0, r_txShift[7:1]};
                            r_txLine  <= r_txShift[1];
                        end
                    end else begin
                        r_txClkCnt <= r_txClkCnt + CW'(1);
                    end
                end
                TX_STOP: begin
                    r_txLine <= 1'b1;
                    if (w_txTick) begin
                        r_txClkCnt <= '0;
                    end else begin
                        r_txClkCnt <= r_txClkCnt + CW'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counters_uart_monitor.sv
// ---------------------------------------------------------------------------
// tb_counters_uart_monitor
//
// Self-checking bench for counters_uart_monitor with CLKS_PER_BIT = 4.
// A timeline model tracks the expected counter value and the expected TX
// line level every cycle. Commands received by the DUT are modelled as
// events that take effect a fixed number of edges after the start bit is
// driven onto the RX pin; each 'S' response is modelled as a 10-bit frame
// laid out over time from the snapshot byte.
// ---------------------------------------------------------------------------
module tb_counters_uart_monitor;

    localparam int CPB        = 4;
    localparam int FRAME      = 10 * CPB;
    localparam int RX_LATENCY = (19 * CPB) / 2 + 3;

    typedef struct {
        int         validEdge;
        logic [7:0] data;
    } rxEvent_t;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       rxPin   = 1'b1;
    logic [7:0] cntb;
    logic       txLine;

    int         checks  = 0;
    int         errors  = 0;
    int         edgeNum = 0;

    logic [7:0] modelCnt  = 8'h00;
    logic       modelLine = 1'b1;
    logic       txValid   = 1'b0;
    int         txStart   = 0;
    logic [7:0] txByte    = 8'h00;
    rxEvent_t   evq[$];

    counters_uart_monitor #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cntb           (cntb),
        .uart_XMIT_dataH(txLine),
        .uart_REC_dataH (rxPin)
    );

    // Free-running 100 MHz-style clock.
    always #5 clk = ~clk;

    // Compare both DUT outputs against the model for the current cycle.
    task automatic checkOutput();
        checks++;
        assert (cntb === modelCnt) else begin
            errors++;
            $error("[TB] FAIL cntb edge=%0d observed=%02h expected=%02h",
                   edgeNum, cntb, modelCnt);
        end
        checks++;
        assert (txLine === modelLine) else begin
            errors++;
            $error("[TB] FAIL txLine edge=%0d observed=%0b expected=%0b",
                   edgeNum, txLine, modelLine);
        end
    endtask

    // Advance one clock edge, update the model for that edge, then check
    // the outputs 1 time unit later.
    task automatic advanceCycle();
        logic [7:0] prevCnt;
        rxEvent_t   ev;
        int         bitPos;
        @(posedge clk);
        edgeNum++;
        if (reset) begin
            modelCnt = 8'h00;
            txValid  = 1'b0;
            evq.delete();
        end else begin
            prevCnt  = modelCnt;
            modelCnt = modelCnt + 8'd1;
            if (evq.size() > 0 && evq[0].validEdge + 1 == edgeNum) begin
                ev = evq.pop_front();
                if (ev.data == 8'h43) begin
                    modelCnt = 8'h00;
                end else if (ev.data == 8'h53) begin
                    if (!(txValid && (edgeNum - 1 - txStart) < FRAME)) begin
                        txValid = 1'b1;
                        txStart = edgeNum;
                        txByte  = prevCnt;
                    end
                end
            end
        end
        modelLine = 1'b1;
        if (txValid && (edgeNum - txStart) < FRAME) begin
            bitPos = (edgeNum - txStart) / CPB;
            if (bitPos == 0) begin
                modelLine = 1'b0;
            end else if (bitPos <= 8) begin
                modelLine = txByte[bitPos-1];
            end
        end
        #1;
        checkOutput();
    endtask

    task automatic waitCycles(input int n);
        repeat (n) advanceCycle();
    endtask

    // Serialise one 8N1 frame onto the RX pin. A good stop bit schedules
    // the command event in the model.
    task automatic applyStimulus(input logic [7:0] b, input logic stopOk);
        rxEvent_t ev;
        if (stopOk) begin
            ev.validEdge = edgeNum + RX_LATENCY;
            ev.data      = b;
            evq.push_back(ev);
        end
        rxPin = 1'b0;
        repeat (CPB) advanceCycle();
        for (int i = 0; i < 8; i++) begin
            rxPin = b[i];
            repeat (CPB) advanceCycle();
        end
        rxPin = stopOk;
        repeat (CPB) advanceCycle();
        rxPin = 1'b1;
    endtask

    initial begin
        logic [7:0] rb;

        // Reset held for 10 cycles, then a long run across the 0xFF wrap.
        reset = 1'b1;
        rxPin = 1'b1;
        waitCycles(10);
        reset = 1'b0;
        waitCycles(300);

        // Snapshot, clear, ignored byte.
        waitCycles($urandom_range(1, 20));
        applyStimulus(8'h53, 1'b1);
        waitCycles(50);
        applyStimulus(8'h43, 1'b1);
        waitCycles(20);
        applyStimulus(8'h41, 1'b1);
        waitCycles(45);

        // Random non-command bytes must leave everything untouched.
        for (int i = 0; i < 6; i++) begin
            do begin
                rb = 8'($urandom_range(0, 255));
            end while (rb == 8'h53 || rb == 8'h43);
            applyStimulus(rb, 1'b1);
            waitCycles($urandom_range(1, 12));
        end

        // Framing error on an 'S': no response expected.
        applyStimulus(8'h53, 1'b0);
        waitCycles(20);

        // One-cycle start glitch.
        rxPin = 1'b0;
        advanceCycle();
        rxPin = 1'b1;
        waitCycles(10);

        // Busy drop: second 'S' lands in the last stop-bit cycle, then a
        // third 'S' later gives a fresh frame.
        applyStimulus(8'h53, 1'b1);
        applyStimulus(8'h53, 1'b1);
        waitCycles(10);
        applyStimulus(8'h53, 1'b1);
        advanceCycle();
        applyStimulus(8'h53, 1'b1);
        waitCycles(50);

        // 'C' arriving while TX is busy still clears.
        applyStimulus(8'h53, 1'b1);
        applyStimulus(8'h43, 1'b1);
        waitCycles(50);

        // Randomised mix of snapshots and clears at random phases.
        for (int i = 0; i < 6; i++) begin
            waitCycles($urandom_range(1, 60));
            applyStimulus(($urandom_range(0, 1) == 1) ? 8'h53 : 8'h43, 1'b1);
        end
        waitCycles(50);

        // Reset asserted on the very edge the 'S' command would load TX.
        applyStimulus(8'h53, 1'b1);
        advanceCycle();
        reset = 1'b1;
        advanceCycle();
        reset = 1'b0;
        waitCycles(50);

        // Reset halfway through a TX frame, then a normal snapshot.
        applyStimulus(8'h53, 1'b1);
        waitCycles(2 + FRAME / 2);
        reset = 1'b1;
        advanceCycle();
        reset = 1'b0;
        waitCycles(5);
        applyStimulus(8'h53, 1'b1);
        waitCycles(50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
